menu_controller: RTL and testbench

MENU_CONTROLLER -- requirements
Module: menu_controller

---
 rtl/menu_controller.sv | 114 +++++++++++
 tb/tb_menu_controller.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/menu_controller.sv
// menu_controller: two-state (BROWSE/EDIT) menu engine driven by debounced
// button pulses. Holds one 7-bit value per item, presents the selected item's
// value as registered BCD digits, and raises a display refresh request that
// coalesces events until the display writer acknowledges.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   up_pulse, down_pulse  navigation / value step pulses (one cycle)
//   sel_pulse             toggles BROWSE <-> EDIT (one cycle)
//   upd_ack               display writer consumed current fields
//   upd_req               refresh request, held until acknowledged
//   item_idx              selected item
//   value_tens/ones       BCD digits of the selected item's value
//   edit_mode             1 = EDIT, 0 = BROWSE
module menu_controller #(
  parameter int NUM_ITEMS    = 4,
  parameter int MAX_VALUE    = 99,
  parameter int EDIT_TIMEOUT = 500000000,
  localparam int IDX_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_pulse,
  input  logic             down_pulse,
  input  logic             sel_pulse,
  input  logic             upd_ack,
  output logic             upd_req,
  output logic [IDX_W-1:0] item_idx,
  output logic [3:0]       value_tens,
  output logic [3:0]       value_ones,
  output logic             edit_mode
);

  localparam int CNT_W = $clog2(EDIT_TIMEOUT + 1);

  typedef enum logic {BROWSE = 1'b0, EDIT = 1'b1} state_t;

  state_t           state, state_n;
  logic [6:0]       vals [NUM_ITEMS];
  logic [IDX_W-1:0] idx_n;
  logic [6:0]       cur_val, val_n, disp_val;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             wr, evt, pulse, init_done, req_n;

  assign pulse     = up_pulse | down_pulse | sel_pulse;
  assign cur_val   = vals[item_idx];
  assign edit_mode = (state == EDIT);

  always_comb begin
    state_n = state;
    idx_n   = item_idx;
    val_n   = cur_val;
    wr      = 1'b0;
    evt     = 1'b0;
    if (sel_pulse) begin
      // select wins over any simultaneous up/down
      state_n = (state == BROWSE) ? EDIT : BROWSE;
      evt     = 1'b1;
    end else if (up_pulse ^ down_pulse) begin
      // up+down together cancel out and are not an event
      evt = 1'b1;
      if (state == BROWSE) begin
        if (up_pulse)
          idx_n = (item_idx == IDX_W'(NUM_ITEMS - 1)) ? '0 : item_idx + 1'b1;
        else
          idx_n = (item_idx == '0) ? IDX_W'(NUM_ITEMS - 1) : item_idx - 1'b1;
      end else begin
        wr = 1'b1;
        if (up_pulse)
          val_n = (cur_val == 7'(MAX_VALUE)) ? 7'd0 : cur_val + 7'd1;
        else
          val_n = (cur_val == 7'd0) ? 7'(MAX_VALUE) : cur_val - 7'd1;
      end
    end else if (state == EDIT && !pulse && cnt == CNT_W'(EDIT_TIMEOUT - 1)) begin
      state_n = BROWSE;
      evt     = 1'b1;
    end

    // counts pulse-free cycles spent in EDIT; zero on entry, on any pulse,
    // and throughout BROWSE
    cnt_n = (state == EDIT && state_n == EDIT && !pulse) ? cnt + 1'b1 : '0;

    // digits track the value that will be selected after this edge
    disp_val = wr ? val_n : vals[idx_n];

    // first edge after reset forces one initial draw request
    if (evt || !init_done) req_n = 1'b1;
    else if (upd_ack)      req_n = 1'b0;
    else                   req_n = upd_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BROWSE;
      item_idx   <= '0;
      value_tens <= '0;
      value_ones <= '0;
      cnt        <= '0;
      upd_req    <= 1'b0;
      init_done  <= 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++) vals[i] <= '0;
    end else begin
      state      <= state_n;
      item_idx   <= idx_n;
      value_tens <= 4'(disp_val / 7'd10);
      value_ones <= 4'(disp_val % 7'd10);
      cnt        <= cnt_n;
      upd_req    <= req_n;
      init_done  <= 1'b1;
      if (wr) vals[item_idx] <= val_n;
    end
  end

endmodule

// File: tb/tb_menu_controller.sv
// Bench for menu_controller: directed vector table, hand sequences for
// timeout and mid-operation reset, then random pulses against a model.
module tb_menu_controller;
  localparam int N  = 4;
  localparam int MX = 99;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       up_pulse = 1'b0, down_pulse = 1'b0, sel_pulse = 1'b0, upd_ack = 1'b0;
  logic       upd_req, edit_mode;
  logic [1:0] item_idx;
  logic [3:0] value_tens, value_ones;

  menu_controller #(.NUM_ITEMS(N), .MAX_VALUE(MX), .EDIT_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .up_pulse(up_pulse), .down_pulse(down_pulse),
    .sel_pulse(sel_pulse), .upd_ack(upd_ack), .upd_req(upd_req),
    .item_idx(item_idx), .value_tens(value_tens), .value_ones(value_ones),
    .edit_mode(edit_mode)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // reference model: plain integers and modular arithmetic
  int m_idx, m_idle;
  int m_vals [N];
  bit m_edit, m_req, m_first;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idx = 0; m_idle = 0; m_edit = 0; m_req = 0; m_first = 1;
    for (int i = 0; i < N; i++) m_vals[i] = 0;
  endtask

  task automatic model_update(input bit u, d, s, a);
    bit ev = 0;
    if (s) begin
      m_edit = !m_edit; m_idle = 0; ev = 1;
    end else if (u != d) begin
      ev = 1; m_idle = 0;
      if (!m_edit) m_idx = (m_idx + (u ? 1 : N - 1)) % N;
      else m_vals[m_idx] = (m_vals[m_idx] + (u ? 1 : MX)) % (MX + 1);
    end else if (m_edit) begin
      if (u) m_idle = 0;  // up and down together still count as activity
      else begin
        m_idle++;
        if (m_idle == TO) begin m_edit = 0; m_idle = 0; ev = 1; end
      end
    end
    if (m_first || ev) m_req = 1;
    else if (a) m_req = 0;
    m_first = 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".idx"},  int'(item_idx),   m_idx);
    chk({tag, ".tens"}, int'(value_tens), m_vals[m_idx] / 10);
    chk({tag, ".ones"}, int'(value_ones), m_vals[m_idx] % 10);
    chk({tag, ".edit"}, int'(edit_mode),  int'(m_edit));
    chk({tag, ".req"},  int'(upd_req),    int'(m_req));
  endtask

  task automatic step(input bit u, d, s, a);
    @(negedge clk);
    up_pulse = u; down_pulse = d; sel_pulse = s; upd_ack = a;
    @(posedge clk);
    model_update(u, d, s, a);
    #1;
    check_model("model");
  endtask

  typedef struct {
    bit u, d, s, a;
    int idx, tens, ones;
    bit e, r;
  } vec_t;

  vec_t tbl [22];

  initial begin
    //          u  d  s  a  idx t  o  e  r
    tbl[0]  = '{0, 1, 0, 0, 3, 0, 0, 0, 1};
    tbl[1]  = '{0, 1, 0, 0, 2, 0, 0, 0, 1};
    tbl[2]  = '{0, 1, 0, 0, 1, 0, 0, 0, 1};
    tbl[3]  = '{0, 1, 0, 0, 0, 0, 0, 0, 1};
    tbl[4]  = '{1, 0, 0, 1, 1, 0, 0, 0, 1};
    tbl[5]  = '{0, 0, 0, 1, 1, 0, 0, 0, 0};
    tbl[6]  = '{1, 0, 0, 0, 2, 0, 0, 0, 1};
    tbl[7]  = '{0, 0, 1, 1, 2, 0, 0, 1, 1};
    tbl[8]  = '{0, 1, 0, 0, 2, 9, 9, 1, 1};
    tbl[9]  = '{1, 0, 0, 0, 2, 0, 0, 1, 1};
    tbl[10] = '{1, 1, 0, 1, 2, 0, 0, 1, 0};
    tbl[11] = '{1, 1, 0, 0, 2, 0, 0, 1, 0};
    tbl[12] = '{0, 0, 1, 0, 2, 0, 0, 0, 1};
    tbl[13] = '{0, 0, 0, 1, 2, 0, 0, 0, 0};
    tbl[14] = '{1, 0, 1, 0, 2, 0, 0, 1, 1};
    tbl[15] = '{0, 0, 0, 1, 2, 0, 0, 1, 0};
    tbl[16] = '{1, 0, 0, 0, 2, 0, 1, 1, 1};
    tbl[17] = '{1, 0, 0, 1, 2, 0, 2, 1, 1};
    tbl[18] = '{0, 0, 0, 1, 2, 0, 2, 1, 0};
    tbl[19] = '{0, 0, 1, 0, 2, 0, 2, 0, 1};
    tbl[20] = '{0, 0, 0, 1, 2, 0, 2, 0, 0};
    tbl[21] = '{0, 0, 0, 1, 2, 0, 2, 0, 0};

    model_reset();
    #12;
    // outputs during reset
    chk("rst.idx",  int'(item_idx), 0);
    chk("rst.tens", int'(value_tens), 0);
    chk("rst.ones", int'(value_ones), 0);
    chk("rst.edit", int'(edit_mode), 0);
    chk("rst.req",  int'(upd_req), 0);

    @(negedge clk); rst_n = 1'b1;
    step(0, 0, 0, 0);
    chk("init.req", int'(upd_req), 1);
    step(0, 0, 0, 0);
    chk("init.hold", int'(upd_req), 1);
    step(0, 0, 0, 1);
    chk("init.ack", int'(upd_req), 0);

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].u, tbl[i].d, tbl[i].s, tbl[i].a);
      chk($sformatf("vec%0d.idx", i),  int'(item_idx),   tbl[i].idx);
      chk($sformatf("vec%0d.tens", i), int'(value_tens), tbl[i].tens);
      chk($sformatf("vec%0d.ones", i), int'(value_ones), tbl[i].ones);
      chk($sformatf("vec%0d.edit", i), int'(edit_mode),  int'(tbl[i].e));
      chk($sformatf("vec%0d.req", i),  int'(upd_req),    int'(tbl[i].r));
    end

    // inactivity timeout: entry edge, then TO-1 idle edges stay in EDIT
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    for (int i = 0; i < TO - 2; i++) step(0, 0, 0, 0);
    chk("to.still_edit", int'(edit_mode), 1);
    chk("to.req_clear", int'(upd_req), 0);
    step(0, 0, 0, 0);
    chk("to.exit", int'(edit_mode), 0);
    chk("to.req", int'(upd_req), 1);
    chk("to.keep", int'(value_ones), 2);

    // asynchronous reset mid-operation with a pending request
    step(1, 0, 0, 0);
    chk("mid.idx_pre", int'(item_idx), 3);
    @(negedge clk);
    up_pulse = 0; down_pulse = 0; sel_pulse = 0; upd_ack = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid.req", int'(upd_req), 0);
    chk("mid.idx", int'(item_idx), 0);
    chk("mid.edit", int'(edit_mode), 0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    step(0, 0, 0, 0);
    chk("mid.redraw", int'(upd_req), 1);

    // random pulses, with periodic quiet stretches so timeouts occur
    for (int c = 0; c < 800; c++) begin
      bit quiet = (c % 120) >= 95;
      bit u = !quiet && ($urandom_range(0, 4) == 0);
      bit d = !quiet && ($urandom_range(0, 4) == 0);
      bit s = !quiet && ($urandom_range(0, 9) == 0);
      bit a = ($urandom_range(0, 2) == 0);
      step(u, d, s, a);
    end

    @(negedge clk);
    up_pulse = 0; down_pulse = 0; sel_pulse = 0; upd_ack = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
